// File: rtl/cache_nway_wb_ctrl_pkg.sv
// Shared definitions for the N-way write-back cache controller: FSM state
// encodings and a width helper that keeps index fields at least one bit wide.
package cache_nway_wb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOOKUP      = 3'd1,
    ST_WB          = 3'd2,
    ST_REFILL_REQ  = 3'd3,
    ST_REFILL_WAIT = 3'd4,
    ST_RESP        = 3'd5
  } state_e;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: the lowest-index invalid way if the set has one,
// otherwise the set's round-robin pointer. Purely combinational.
module cache_victim_sel
  import cache_nway_wb_ctrl_pkg::*;
#(
  parameter int WAY_NUM = 4
) (
  input  logic [WAY_NUM-1:0]             valid_i,
  input  logic [clog2_min1(WAY_NUM)-1:0] rr_ptr_i,
  output logic [clog2_min1(WAY_NUM)-1:0] victim_o
);

  localparam int WAY_W = clog2_min1(WAY_NUM);

  // Descending scan so the lowest invalid way overrides the pointer fallback.
  always_comb begin
    victim_o = rr_ptr_i;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      victim_o = (!valid_i[w]) ? WAY_W'(w) : victim_o;
    end
  end

endmodule

// File: rtl/cache_nway_wb_ctrl.sv
// N-way set-associative write-back / write-allocate data cache with a
// stall-until-refill miss path. Dirty victims go to the write buffer before
// the refill request is issued; clean victims are simply overwritten.
module cache_nway_wb_ctrl
  import cache_nway_wb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int WAY_NUM    = 4,
  parameter int SET_NUM    = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_wr,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [WORD_WIDTH-1:0]            cpu_wdata,
  output logic                             cpu_rsp_valid,
  output logic [WORD_WIDTH-1:0]            cpu_rdata,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ADDR_WIDTH-1:0]            wb_addr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] wb_data,
  output logic                             mem_rd_valid,
  input  logic                             mem_rd_ready,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic                             mem_rd_data_valid,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rd_data
);

  localparam int WORD_BYTES   = WORD_WIDTH / 8;
  localparam int BYTE_OFF     = $clog2(WORD_BYTES);
  localparam int OFFSET_WIDTH = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int INDEX_WIDTH  = $clog2(SET_NUM);
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_WIDTH   = LINE_WORDS * WORD_WIDTH;
  localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W        = clog2_min1(WAY_NUM);
  localparam int WSEL_W       = clog2_min1(LINE_WORDS);

  // Storage arrays
  logic [WAY_NUM-1:0]    valid_q [SET_NUM];
  logic [WAY_NUM-1:0]    dirty_q [SET_NUM];
  logic [WAY_W-1:0]      rr_q    [SET_NUM];
  logic [TAG_WIDTH-1:0]  tag_q   [SET_NUM][WAY_NUM];
  logic [LINE_WIDTH-1:0] data_q  [SET_NUM][WAY_NUM];

  // Controller state and latched request
  state_e                 state_q, state_d;
  logic                   ready_q;
  logic                   req_wr_q;
  logic [LADDR_WIDTH-1:0] req_line_q;
  logic [WSEL_W-1:0]      wsel_q;
  logic [WORD_WIDTH-1:0]  req_wdata_q;
  logic [WAY_W-1:0]       victim_q;

  // Combinational
  logic [WSEL_W-1:0]      cpu_wsel_s;
  logic [INDEX_WIDTH-1:0] idx_s;
  logic [TAG_WIDTH-1:0]   tag_s;
  logic [WAY_NUM-1:0]     match_s;
  logic                   hit_s;
  logic [WAY_W-1:0]       hit_way_s;
  logic [WAY_W-1:0]       victim_s;
  logic                   victim_valid_s;
  logic                   victim_dirty_s;
  logic [WAY_W-1:0]       rr_next_s;
  logic [LINE_WIDTH-1:0]  hit_line_s;
  logic [LINE_WIDTH-1:0]  victim_line_s;
  logic [LINE_WIDTH-1:0]  fill_line_s;
  logic [ADDR_WIDTH-1:0]  victim_addr_s;
  logic                   accept_s;
  logic                   rsp_valid_s;
  logic [WORD_WIDTH-1:0]  rdata_s;
  logic                   wb_valid_s;
  logic                   mem_rd_valid_s;
  logic                   hit_wr_s;
  logic                   miss_s;
  logic                   install_s;

  function automatic logic [WORD_WIDTH-1:0] get_word(input logic [LINE_WIDTH-1:0] line,
                                                     input logic [WSEL_W-1:0]     sel);
    return line[sel*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  function automatic logic [LINE_WIDTH-1:0] put_word(input logic [LINE_WIDTH-1:0] line,
                                                     input logic [WSEL_W-1:0]     sel,
                                                     input logic [WORD_WIDTH-1:0] word);
    logic [LINE_WIDTH-1:0] res;
    res = line;
    res[sel*WORD_WIDTH +: WORD_WIDTH] = word;
    return res;
  endfunction

  // Word-within-line select; single-word lines always use word 0.
  generate
    if (LINE_WORDS > 1) begin : g_wsel
      assign cpu_wsel_s = cpu_addr[OFFSET_WIDTH-1:BYTE_OFF];
    end else begin : g_wsel_zero
      assign cpu_wsel_s = {WSEL_W{1'b0}};
    end
    if (BYTE_OFF > 0) begin : g_byte_off
      // Byte-within-word address bits carry no meaning for word accesses.
      logic unused_byte_addr_s;
      assign unused_byte_addr_s = ^cpu_addr[BYTE_OFF-1:0];
    end
  endgenerate

  assign accept_s = cpu_req_valid && ready_q && (state_q == ST_IDLE);
  assign idx_s    = req_line_q[INDEX_WIDTH-1:0];
  assign tag_s    = req_line_q[LADDR_WIDTH-1 -: TAG_WIDTH];

  // Per-way tag match within the addressed set.
  always_comb begin
    match_s = {WAY_NUM{1'b0}};
    for (int w = 0; w < WAY_NUM; w++) begin
      match_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
    end
  end

  // Priority encode the match vector: the lowest matching way wins.
  always_comb begin
    hit_way_s = {WAY_W{1'b0}};
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      hit_way_s = match_s[w] ? WAY_W'(w) : hit_way_s;
    end
  end

  assign hit_s = |match_s;

  cache_victim_sel #(
    .WAY_NUM (WAY_NUM)
  ) u_victim_sel (
    .valid_i  (valid_q[idx_s]),
    .rr_ptr_i (rr_q[idx_s]),
    .victim_o (victim_s)
  );

  assign victim_valid_s = valid_q[idx_s][victim_s];
  assign victim_dirty_s = valid_q[idx_s][victim_s] && dirty_q[idx_s][victim_s];
  assign rr_next_s      = (rr_q[idx_s] == WAY_W'(WAY_NUM - 1)) ? {WAY_W{1'b0}}
                                                                : rr_q[idx_s] + 1'b1;
  assign hit_line_s     = data_q[idx_s][hit_way_s];
  assign victim_line_s  = data_q[idx_s][victim_q];
  assign victim_addr_s  = ADDR_WIDTH'({tag_q[idx_s][victim_q], idx_s}) << OFFSET_WIDTH;
  assign fill_line_s    = req_wr_q ? put_word(mem_rd_data, wsel_q, req_wdata_q) : mem_rd_data;

  // Next-state and per-state output decode for the miss/hit controller.
  always_comb begin
    state_d        = state_q;
    rsp_valid_s    = 1'b0;
    rdata_s        = {WORD_WIDTH{1'b0}};
    wb_valid_s     = 1'b0;
    mem_rd_valid_s = 1'b0;
    hit_wr_s       = 1'b0;
    miss_s         = 1'b0;
    install_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_LOOKUP;
        else          state_d = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          rsp_valid_s = 1'b1;
          rdata_s     = req_wr_q ? {WORD_WIDTH{1'b0}} : get_word(hit_line_s, wsel_q);
          hit_wr_s    = req_wr_q;
          state_d     = ST_IDLE;
        end else begin
          miss_s  = 1'b1;
          state_d = victim_dirty_s ? ST_WB : ST_REFILL_REQ;
        end
      end
      ST_WB: begin
        wb_valid_s = 1'b1;
        if (wb_ready) state_d = ST_REFILL_REQ;
        else          state_d = ST_WB;
      end
      ST_REFILL_REQ: begin
        mem_rd_valid_s = 1'b1;
        if (mem_rd_ready) state_d = ST_REFILL_WAIT;
        else              state_d = ST_REFILL_REQ;
      end
      ST_REFILL_WAIT: begin
        if (mem_rd_data_valid) begin
          install_s = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_REFILL_WAIT;
        end
      end
      ST_RESP: begin
        rsp_valid_s = 1'b1;
        rdata_s     = req_wr_q ? {WORD_WIDTH{1'b0}} : get_word(victim_line_s, wsel_q);
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, ready flop and request/victim capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      req_wr_q    <= 1'b0;
      req_line_q  <= {LADDR_WIDTH{1'b0}};
      wsel_q      <= {WSEL_W{1'b0}};
      req_wdata_q <= {WORD_WIDTH{1'b0}};
      victim_q    <= {WAY_W{1'b0}};
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      if (accept_s) begin
        req_wr_q    <= cpu_wr;
        req_line_q  <= cpu_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
        wsel_q      <= cpu_wsel_s;
        req_wdata_q <= cpu_wdata;
      end
      if (miss_s) begin
        victim_q <= victim_s;
      end
    end
  end

  // Cache arrays: store-hit word merge, line install and round-robin advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= {WAY_NUM{1'b0}};
        dirty_q[s] <= {WAY_NUM{1'b0}};
        rr_q[s]    <= {WAY_W{1'b0}};
        for (int w = 0; w < WAY_NUM; w++) begin
          tag_q[s][w]  <= {TAG_WIDTH{1'b0}};
          data_q[s][w] <= {LINE_WIDTH{1'b0}};
        end
      end
    end else begin
      if (hit_wr_s) begin
        data_q[idx_s][hit_way_s]  <= put_word(hit_line_s, wsel_q, req_wdata_q);
        dirty_q[idx_s][hit_way_s] <= 1'b1;
      end
      // Only evicting a valid line moves the pointer; filling a hole does not.
      if (miss_s && victim_valid_s) begin
        rr_q[idx_s] <= rr_next_s;
      end
      if (install_s) begin
        data_q[idx_s][victim_q]  <= fill_line_s;
        tag_q[idx_s][victim_q]   <= tag_s;
        valid_q[idx_s][victim_q] <= 1'b1;
        dirty_q[idx_s][victim_q] <= req_wr_q;
      end
    end
  end

  assign cpu_req_ready = ready_q;
  assign cpu_rsp_valid = rsp_valid_s;
  assign cpu_rdata     = rdata_s;
  assign wb_valid      = wb_valid_s;
  assign wb_addr       = wb_valid_s ? victim_addr_s : {ADDR_WIDTH{1'b0}};
  assign wb_data       = wb_valid_s ? victim_line_s : {LINE_WIDTH{1'b0}};
  assign mem_rd_valid  = mem_rd_valid_s;
  assign mem_rd_addr   = mem_rd_valid_s ? (ADDR_WIDTH'(req_line_q) << OFFSET_WIDTH)
                                        : {ADDR_WIDTH{1'b0}};

endmodule
